// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. A request is
// granted in IDLE, its fields are registered, the ALU is driven for one EXEC
// cycle, and the captured result is held in RESP until the consumer accepts it.
// Contention is resolved round-robin. The first contention after reset goes to
// RR_INIT.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid / reqN_ready   requester N handshake (ready == grant, IDLE only)
//   reqN_op/_a/_b/_shamt      requester N operation code, operands, shift amount
//   alu_op/_data1/_data2/_shamt
//                             fields driven to the shared ALU (idle value
//                             outside EXEC)
//   alu_result                combinational result from the shared ALU
//   rsp_valid / rsp_ready     response handshake
//   rsp_id                    requester that owns the response
//   rsp_result                captured ALU result (0 for an undefined op)
//   rsp_zero                  rsp_result == 0
//   rsp_err                   op code was undefined
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_shamt,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_shamt,

    output logic [3:0]  alu_op,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic [3:0] OpIdle = 4'b0010;

    state_e      state_q, state_d;
    logic        last_q, last_d;      // requester granted most recently
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  shamt_q, shamt_d;
    logic        id_q, id_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_err_q, rsp_err_d;

    logic        grant0, grant1, grant;
    logic        op_defined;

    // Only the op codes the shared ALU implements produce a real result.
    always_comb begin
        unique case (op_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
            4'b1100, 4'b1000, 4'b1001, 4'b1010: op_defined = 1'b1;
            default:                            op_defined = 1'b0;
        endcase
    end

    // Grant selection. Under contention the requester not granted last wins;
    // last_q resets to ~RR_INIT so the first contention goes to RR_INIT.
    // No grant is issued while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (req0_valid && req1_valid) begin
                if (last_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
        grant = grant0 | grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        shamt_d      = shamt_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    // Operands are sampled only on the grant edge.
                    op_d    = grant1 ? req1_op    : req0_op;
                    a_d     = grant1 ? req1_a     : req0_a;
                    b_d     = grant1 ? req1_b     : req0_b;
                    shamt_d = grant1 ? req1_shamt : req0_shamt;
                    id_d    = grant1;
                    last_d  = grant1;
                    state_d = StExec;
                end
            end
            StExec: begin
                // Undefined ops still take the full sequence but return 0.
                rsp_result_d = op_defined ? alu_result : 32'd0;
                rsp_zero_d   = op_defined ? (alu_result == 32'd0) : 1'b1;
                rsp_err_d    = ~op_defined;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = StResp;
            end
            StResp: begin
                // Retiring costs a cycle: the grant can only follow in IDLE.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State registers. Reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_q       <= ~RR_INIT;
            op_q         <= OpIdle;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            shamt_q      <= 5'd0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            shamt_q      <= shamt_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // The ALU sees the registered fields only during EXEC; otherwise a benign
    // ADD of zeros.
    always_comb begin
        alu_op    = OpIdle;
        alu_data1 = 32'd0;
        alu_data2 = 32'd0;
        alu_shamt = 5'd0;
        if (state_q == StExec) begin
            alu_op    = op_q;
            alu_data1 = a_q;
            alu_data2 = b_q;
            alu_shamt = shamt_q;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_INIT, 1'b0, requester favoured on the first contention after reset (0 = req0, 1 = req1).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid / req1_valid  input  1  request present from requester 0 / 1.
REQ-005 Port: req0_ready / req1_ready  output  1  request accepted this cycle (grant).
REQ-006 Port: req0_op / req1_op  input  4  ALU operation code.
REQ-007 Port: req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-008 Port: req0_shamt / req1_shamt  input  5  shift amount.
REQ-009 Port: alu_op  output  4  code driven to the shared ALU.
REQ-010 Port: alu_data1, alu_data2  output  32  operands driven to the ALU.
REQ-011 Port: alu_shamt  output  5  shift amount driven to the ALU.
REQ-012 Port: alu_result  input  32  combinational ALU result.
REQ-013 Port: rsp_valid  output  1  response held and valid.
REQ-014 Port: rsp_ready  input  1  consumer accepts the response.
REQ-015 Port: rsp_id  output  1  requester that owns the response.
REQ-016 Port: rsp_result  output  32  captured ALU result.
REQ-017 Port: rsp_zero  output  1  1 when rsp_result == 0.
REQ-018 Port: rsp_err  output  1  1 when the op code was undefined.

Function
REQ-019 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-020 IDLE: at most one of req0_ready/req1_ready asserts, and only in IDLE; a grant occurs when the selected reqN_valid is 1.
REQ-021 One valid request only: grant it.
REQ-022 Both valid: grant the requester not granted most recently. Before any grant, grant RR_INIT.
REQ-023 On a grant, op, a, b, shamt and id are registered. The FSM moves to EXEC and the last-grant pointer updates.
REQ-024 EXEC lasts exactly one cycle. alu_* outputs drive the registered fields, and alu_result is captured at the end of EXEC into rsp_result.
REQ-025 In every state other than EXEC, alu_op = 4'b0010 and alu_data1 = alu_data2 = alu_shamt = 0.
REQ-026 Defined op codes are 0000, 0001, 0010, 0110, 0111, 1100, 1000, 1001, 1010. Any other code is still sequenced, but rsp_result = 0 and rsp_err = 1.
REQ-027 The first cycle of RESP has rsp_valid = 1. Latency is two cycles from grant edge to rsp_valid.
REQ-028 RESP: rsp_id, rsp_result, rsp_zero and rsp_err remain stable while rsp_valid = 1 and rsp_ready = 0.
REQ-029 RESP with rsp_ready = 1: the response retires and the FSM returns to IDLE. No new grant occurs in that cycle, so the next grant is no earlier than the following cycle.
REQ-030 Maximum throughput is one operation per three cycles. There is no request queue, and unselected requesters see ready = 0.
REQ-031 rsp_zero is computed from the captured rsp_result, with 1 meaning zero, independent of any ALU flag.
REQ-032 A requester dropping valid without a grant has no effect. Operands are sampled only on the grant edge.

Reset
REQ-033 When rst = 1 at a clock edge: state = IDLE, last-grant pointer = ~RR_INIT, and rsp_valid, rsp_id, rsp_result, rsp_zero and rsp_err = 0. No ready is asserted in that cycle.
REQ-034 A reset in EXEC or RESP discards the in-flight operation, and no response is produced for it.

Verification
REQ-035 req0 ADD a = 5, b = 7 alone -> req0_ready at T, alu_op = 0010 at T+1, rsp_valid at T+2 with id = 0, result = 12, zero = 0, err = 0.
REQ-036 Both valid continuously, RR_INIT = 0, rsp_ready = 1 -> grant order 0,1,0,1, one grant every 3 cycles.
REQ-037 req1 SUB a = 9, b = 9 with rsp_ready = 0 for 4 cycles -> rsp_valid held, result = 0, zero = 1, id = 1 stable; retires when rsp_ready = 1.
REQ-038 req0 op = 4'b0011 -> response result = 0, err = 1; next request serviced normally.
REQ-039 req0 SRA b = 0x80000000, shamt = 4 -> result 0xF8000000 returned through the arbiter unchanged.
REQ-040 rst asserted during EXEC -> next cycle IDLE, rsp_valid = 0, no response for the aborted op; next contention grants RR_INIT.
